// File: rtl/cart_mapper_pkg.sv
// Shared types and constants for the cartridge bank-switching mapper.
package cart_pkg;

  typedef enum logic [2:0] {
    M_2K  = 3'd0,
    M_4K  = 3'd1,
    M_F8  = 3'd2,
    M_F6  = 3'd3,
    M_F4  = 3'd4,
    M_E0  = 3'd5,
    M_3F  = 3'd6,
    M_RSV = 3'd7
  } mapper_e;

  localparam logic [11:0] HOT_F8 = 12'hFF8;
  localparam logic [11:0] HOT_F6 = 12'hFF6;
  localparam logic [11:0] HOT_F4 = 12'hFF4;
  localparam logic [11:0] HOT_E0 = 12'hFE0;

  localparam logic [2:0] SLICE0_RST = 3'd4;
  localparam logic [2:0] SLICE1_RST = 3'd5;
  localparam logic [2:0] SLICE2_RST = 3'd6;

  // Power-up bank is the last bank, where the 6507 reset vector lives.
  function automatic logic [3:0] reset_bank(mapper_e m);
    case (m)
      M_F8:    reset_bank = 4'd1;
      M_F6:    reset_bank = 4'd3;
      M_F4:    reset_bank = 4'd7;
      default: reset_bank = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/cart_mapper_if.sv
// CPU-side bus into the mapper plus the widened ROM address it returns.
interface cart_mapper_if #(parameter int ROM_AW = 15);
  logic              ce;
  logic [12:0]       cpu_addr;
  logic              cpu_rwn;
  logic [7:0]        cpu_wdata;
  logic [ROM_AW-1:0] rom_addr;

  modport master (output ce, cpu_addr, cpu_rwn, cpu_wdata, input rom_addr);
  modport slave  (input ce, cpu_addr, cpu_rwn, cpu_wdata, output rom_addr);
endinterface

// File: rtl/cart_hotspot_decode.sv
// Combinational hotspot decoder: which bank register an access writes, and with what.
module cart_hotspot_decode
  import cart_pkg::*;
#(
  parameter int ROM_AW = 15
) (
  input  mapper_e     mode,
  input  logic [12:0] addr,
  input  logic        rwn,
  input  logic [7:0]  wdata,
  output logic        hit,
  output logic [1:0]  target,
  output logic [3:0]  value
);

  localparam int BANK_W = ROM_AW - 11;
  localparam logic [7:0] BANK_MASK = 8'((1 << BANK_W) - 1);

  logic [11:0] lo;
  logic [11:0] off_f8, off_f6, off_f4, off_e0;

  assign lo     = addr[11:0];
  assign off_f8 = lo - HOT_F8;
  assign off_f6 = lo - HOT_F6;
  assign off_f4 = lo - HOT_F4;
  assign off_e0 = lo - HOT_E0;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    hit    = 1'b0;
    target = 2'd0;
    value  = 4'd0;
    case (mode)
      M_F8: begin
        hit   = addr[12] && (lo >= HOT_F8) && (lo <= HOT_F8 + 12'd1);
        value = 4'(off_f8);
      end
      M_F6: begin
        hit   = addr[12] && (lo >= HOT_F6) && (lo <= HOT_F6 + 12'd3);
        value = 4'(off_f6);
      end
      M_F4: begin
        hit   = addr[12] && (lo >= HOT_F4) && (lo <= HOT_F4 + 12'd7);
        value = 4'(off_f4);
      end
      M_E0: begin
        hit    = addr[12] && (lo >= HOT_E0) && (lo <= HOT_E0 + 12'd23);
        target = 2'(off_e0 >> 3);
        value  = 4'(off_e0 & 12'h007);
      end
      M_3F: begin
        // Shares the TIA write space below $1000; only writes switch banks.
        hit   = !rwn && !addr[12] && (addr[7:6] == 2'b00);
        value = 4'(wdata & BANK_MASK);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cart_mapper.sv
// Cartridge bank-switching controller: bank registers and the ROM address mux.
module cart_mapper
  import cart_pkg::*;
#(
  parameter int ROM_AW = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [2:0]      mapper_mode,
  cart_mapper_if.slave    bus,
  output logic [3:0]      bank_dbg,
  output logic            hotspot_stb
);

  mapper_e     mode_in, mode_q;
  logic [3:0]  bank;
  logic [2:0]  slice0, slice1, slice2;
  logic        hit;
  logic [1:0]  target;
  logic [3:0]  value;
  logic [12:0] a;
  logic [2:0]  sl;
  logic [15:0] addr_w;

  assign mode_in = mapper_e'(mapper_mode);
  assign a       = bus.cpu_addr;

  cart_hotspot_decode #(.ROM_AW(ROM_AW)) u_decode (
    .mode   (mode_q),
    .addr   (a),
    .rwn    (bus.cpu_rwn),
    .wdata  (bus.cpu_wdata),
    .hit    (hit),
    .target (target),
    .value  (value)
  );

  // NOTE: sequential state uses non-blocking assignments only; reset loads the
  // live mode so the bank reset value always matches the selected scheme.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= mode_in;
      bank        <= reset_bank(mode_in);
      slice0      <= SLICE0_RST;
      slice1      <= SLICE1_RST;
      slice2      <= SLICE2_RST;
      hotspot_stb <= 1'b0;
    end else if (mode_in != mode_q) begin
      mode_q      <= mode_in;
      bank        <= reset_bank(mode_in);
      slice0      <= SLICE0_RST;
      slice1      <= SLICE1_RST;
      slice2      <= SLICE2_RST;
      hotspot_stb <= 1'b0;
    end else begin
      hotspot_stb <= bus.ce && hit;
      if (bus.ce && hit) begin
        if (mode_q == M_E0) begin
          case (target)
            2'd0:    slice0 <= value[2:0];
            2'd1:    slice1 <= value[2:0];
            default: slice2 <= value[2:0];
          endcase
        end else begin
          bank <= value;
        end
      end
    end
  end

  always_comb begin
    case (a[11:10])
      2'd0:    sl = slice0;
      2'd1:    sl = slice1;
      2'd2:    sl = slice2;
      default: sl = 3'd7;
    endcase
  end

  // Built 16 bits wide, then truncated; the 3F fixed bank relies on that.
  always_comb begin
    case (mode_q)
      M_2K: addr_w = {5'd0, a[10:0]};
      M_F8: addr_w = {3'd0, bank[0], a[11:0]};
      M_F6: addr_w = {2'd0, bank[1:0], a[11:0]};
      M_F4: addr_w = {1'b0, bank[2:0], a[11:0]};
      M_E0: addr_w = {3'd0, sl, a[9:0]};
      M_3F: addr_w = a[11] ? {5'h1F, a[10:0]} : {1'b0, bank, a[10:0]};
      default: addr_w = {4'd0, a[11:0]};
    endcase
  end

  assign bus.rom_addr = ROM_AW'(addr_w);
  assign bank_dbg     = (mode_q == M_E0) ? {1'b0, slice0} : bank;

endmodule

// File: tb/tb_cart_mapper.sv
// Directed bench for cart_mapper with a queue of expected per-cycle results.
module tb_cart_mapper;
  import cart_pkg::*;

  localparam int ROM_AW = 15;

  typedef struct {
    logic [14:0] rom;
    logic [3:0]  bank;
    logic        stb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] mapper_mode;
  logic [3:0] bank_dbg;
  logic       hotspot_stb;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  cart_mapper_if #(.ROM_AW(ROM_AW)) bus ();

  cart_mapper #(.ROM_AW(ROM_AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mapper_mode (mapper_mode),
    .bus         (bus),
    .bank_dbg    (bank_dbg),
    .hotspot_stb (hotspot_stb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU cycle: rom_addr sampled before the edge, bank/strobe after it.
  task automatic step(input string tag, input logic [2:0] m, input logic c,
                      input logic [12:0] a, input logic rwn, input logic [7:0] d,
                      input logic [14:0] er, input logic [3:0] eb, input logic es);
    exp_t e;
    logic [14:0] obs_rom;
    @(negedge clk);
    mapper_mode   = m;
    bus.ce        = c;
    bus.cpu_addr  = a;
    bus.cpu_rwn   = rwn;
    bus.cpu_wdata = d;
    e.rom = er; e.bank = eb; e.stb = es;
    sb.push_back(e);
    #1;
    obs_rom = bus.rom_addr;
    @(posedge clk);
    #1;
    bus.ce = 1'b0;
    e = sb.pop_front();
    check({tag, "/rom"},  32'(obs_rom),     32'(e.rom));
    check({tag, "/bank"}, 32'(bank_dbg),    32'(e.bank));
    check({tag, "/stb"},  32'(hotspot_stb), 32'(e.stb));
  endtask

  initial begin
    reset_n       = 1'b0;
    mapper_mode   = 3'(M_F8);
    bus.ce        = 1'b0;
    bus.cpu_addr  = 13'h0000;
    bus.cpu_rwn   = 1'b1;
    bus.cpu_wdata = 8'h00;
    #12;
    check("rst/bank", 32'(bank_dbg), 32'd1);
    check("rst/stb",  32'(hotspot_stb), 32'd0);
    check("rst/rom",  32'(bus.rom_addr), 32'h1000);
    @(negedge clk);
    reset_n = 1'b1;

    // F8: hotspot served from old bank, new bank on the next access
    step("f8_rd",    3'(M_F8), 1, 13'h1000, 1, 8'h00, 15'h1000, 4'd1, 0);
    step("f8_hs0",   3'(M_F8), 1, 13'h1FF8, 1, 8'h00, 15'h1FF8, 4'd0, 1);
    step("f8_b0",    3'(M_F8), 1, 13'h1000, 1, 8'h00, 15'h0000, 4'd0, 0);
    step("f8_hs1a",  3'(M_F8), 1, 13'h1FF9, 1, 8'h00, 15'h0FF9, 4'd1, 1);
    step("f8_hs1b",  3'(M_F8), 1, 13'h1FF9, 1, 8'h00, 15'h1FF9, 4'd1, 1);
    step("f8_noce",  3'(M_F8), 0, 13'h1FF8, 1, 8'h00, 15'h1FF8, 4'd1, 0);

    // F4
    step("f4_mode",  3'(M_F4), 0, 13'h1000, 1, 8'h00, 15'h1000, 4'd7, 0);
    step("f4_hs7",   3'(M_F4), 1, 13'h1FFB, 1, 8'h00, 15'h7FFB, 4'd7, 1);
    step("f4_rd7",   3'(M_F4), 1, 13'h1234, 1, 8'h00, 15'h7234, 4'd7, 0);
    step("f4_wr0",   3'(M_F4), 1, 13'h1FF4, 0, 8'h55, 15'h7FF4, 4'd0, 1);
    step("f4_rd0",   3'(M_F4), 1, 13'h1234, 1, 8'h00, 15'h0234, 4'd0, 0);

    // E0
    step("e0_mode",  3'(M_E0), 0, 13'h1000, 1, 8'h00, 15'h0000, 4'd4, 0);
    step("e0_s0",    3'(M_E0), 1, 13'h1FE3, 1, 8'h00, 15'h1FE3, 4'd3, 1);
    step("e0_s1",    3'(M_E0), 1, 13'h1FEA, 1, 8'h00, 15'h1FEA, 4'd3, 1);
    step("e0_s2",    3'(M_E0), 1, 13'h1FF1, 1, 8'h00, 15'h1FF1, 4'd3, 1);
    step("e0_r0",    3'(M_E0), 1, 13'h1000, 1, 8'h00, 15'h0C00, 4'd3, 0);
    step("e0_r1",    3'(M_E0), 1, 13'h1400, 1, 8'h00, 15'h0800, 4'd3, 0);
    step("e0_r2",    3'(M_E0), 1, 13'h1800, 1, 8'h00, 15'h0400, 4'd3, 0);
    step("e0_r3",    3'(M_E0), 1, 13'h1C00, 1, 8'h00, 15'h1C00, 4'd3, 0);

    // 3F: write-only hotspot, data masked to 4 bank bits
    step("3f_mode",  3'(M_3F), 0, 13'h1000, 1, 8'h00, 15'h0C00, 4'd0, 0);
    step("3f_rd",    3'(M_3F), 1, 13'h003F, 1, 8'h02, 15'h003F, 4'd0, 0);
    step("3f_wr2",   3'(M_3F), 1, 13'h003F, 0, 8'h02, 15'h003F, 4'd2, 1);
    step("3f_lo",    3'(M_3F), 1, 13'h1000, 1, 8'h00, 15'h1000, 4'd2, 0);
    step("3f_hi",    3'(M_3F), 1, 13'h1800, 1, 8'h00, 15'h7800, 4'd2, 0);
    step("3f_miss",  3'(M_3F), 1, 13'h0080, 0, 8'h05, 15'h1080, 4'd2, 0);
    step("3f_mask",  3'(M_3F), 1, 13'h003F, 0, 8'h13, 15'h103F, 4'd3, 1);
    step("3f_lo3",   3'(M_3F), 1, 13'h1000, 1, 8'h00, 15'h1800, 4'd3, 0);

    // 2K / 4K / reserved: no hotspots
    step("2k_mode",  3'(M_2K), 0, 13'h1000, 1, 8'h00, 15'h1800, 4'd0, 0);
    step("2k_hs",    3'(M_2K), 1, 13'h1FF8, 1, 8'h00, 15'h07F8, 4'd0, 0);
    step("4k_mode",  3'(M_4K), 0, 13'h1000, 1, 8'h00, 15'h0000, 4'd0, 0);
    step("4k_hs",    3'(M_4K), 1, 13'h1FF8, 1, 8'h00, 15'h0FF8, 4'd0, 0);
    step("rsv_mode", 3'(M_RSV), 0, 13'h1000, 1, 8'h00, 15'h0000, 4'd0, 0);
    step("rsv_hs",   3'(M_RSV), 1, 13'h1FF8, 0, 8'h00, 15'h0FF8, 4'd0, 0);

    // Mode change beats a simultaneous hotspot
    step("f6_mode",  3'(M_F6), 0, 13'h1000, 1, 8'h00, 15'h0000, 4'd3, 0);
    step("prio",     3'(M_F8), 1, 13'h1FF6, 1, 8'h00, 15'h3FF6, 4'd1, 0);
    step("prio_rd",  3'(M_F8), 1, 13'h1000, 1, 8'h00, 15'h1000, 4'd1, 0);

    // Asynchronous reset while the strobe is high
    step("f6_mode2", 3'(M_F6), 0, 13'h1000, 1, 8'h00, 15'h1000, 4'd3, 0);
    step("f6_hs0",   3'(M_F6), 1, 13'h1FF6, 1, 8'h00, 15'h3FF6, 4'd0, 1);
    reset_n = 1'b0;
    #1;
    check("arst/bank", 32'(bank_dbg),     32'd3);
    check("arst/stb",  32'(hotspot_stb),  32'd0);
    check("arst/rom",  32'(bus.rom_addr), 32'h3FF6);
    @(negedge clk);
    reset_n = 1'b1;
    step("f6_hs1",   3'(M_F6), 1, 13'h1FF7, 1, 8'h00, 15'h3FF7, 4'd1, 1);
    step("f6_idle",  3'(M_F6), 0, 13'h1000, 1, 8'h00, 15'h1000, 4'd1, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
